ysyx_24100005_lsu: RTL and testbench

Parametrised multi-cycle load/store unit. It sits between the core's execute stage and the data-memory port.
- Replaces the combinational single-access memory path with a valid/ready request/response handshake on both sides.
- Generates the byte write mask, lane-shifts store data, and extracts plus sign/zero-extends load data.
- Flags misaligned and illegal accesses, and bounds memory latency with a timeout.

---
 rtl/ysyx_24100005_lsu.sv | 185 ++++++++++++++++++
 tb/tb_ysyx_24100005_lsu.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100005_lsu.sv
// rtl/ysyx_24100005_lsu.sv - multi-cycle load/store unit with valid/ready core and memory ports
// Aligns stores into byte lanes, extracts and extends loads, and reports access errors and timeouts.
module ysyx_24100005_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rerr
);
  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CNTW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic [CNTW-1:0]   cnt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [OFFW-1:0]   off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     wmask_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        err_q;

  logic              accept;
  logic              illegal;
  logic              misaligned;
  logic              timed_out;
  logic [1:0]        req_err;
  logic [2:0]        align_mask;
  logic [OFFW-1:0]   req_off;
  logic [7:0]        size_mask;
  logic [15:0]       mask_wide;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] load_val;

  assign accept  = req_valid && (state == IDLE);
  assign req_off = req_addr[OFFW-1:0];

  always_comb begin
    illegal = 1'b0;
    case (req_funct3)
      3'b011:         illegal = (DATA_W != 64);
      3'b100, 3'b101: illegal = req_we;
      3'b110:         illegal = req_we || (DATA_W != 64);
      3'b111:         illegal = 1'b1;
      default:        illegal = 1'b0;
    endcase
  end

  // size code 3 wraps 3'b001<<3 to zero, so the subtraction yields 3'b111
  assign align_mask = (3'b001 << req_funct3[1:0]) - 3'b001;
  assign misaligned = |(req_addr[2:0] & align_mask);
  assign req_err    = illegal ? 2'b10 : (misaligned ? 2'b01 : 2'b00);
  assign timed_out  = (cnt == CNTW'(TIMEOUT - 1));

  always_comb begin
    size_mask = 8'h00;
    case (req_funct3[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0f;
      default: size_mask = 8'hff;
    endcase
  end

  assign mask_wide = {8'h00, size_mask} << req_off;
  assign lane      = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_val = lane;
    case (f3_q)
      3'b000:  load_val = DATA_W'($signed(lane[7:0]));
      3'b001:  load_val = DATA_W'($signed(lane[15:0]));
      3'b010:  load_val = DATA_W'($signed(lane[31:0]));
      3'b100:  load_val = DATA_W'(lane[7:0]);
      3'b101:  load_val = DATA_W'(lane[15:0]);
      3'b110:  load_val = DATA_W'(lane[31:0]);
      default: load_val = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (req_err != 2'b00) ? RESP : ISSUE;
      ISSUE:   if (mem_ready) state_nxt = WAIT;
      WAIT:    if (mem_rvalid || timed_out) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 2'b00;
    case (state)
      IDLE: req_ready = 1'b1;
      ISSUE: begin
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wmask = wmask_q;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 2'b00;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        off_q   <= req_off;
        addr_q  <= {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        wdata_q <= req_we ? (req_wdata << {req_off, 3'b000}) : '0;
        wmask_q <= req_we ? mask_wide[NB-1:0] : '0;
        rdata_q <= '0;
        err_q   <= req_err;
      end
      // responses outside WAIT (late or pre-reset) are never sampled
      if (state == ISSUE) begin
        cnt <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
        if (mem_rvalid) begin
          err_q   <= mem_rerr ? 2'b11 : 2'b00;
          rdata_q <= (mem_rerr || we_q) ? '0 : load_val;
        end else if (timed_out) begin
          err_q <= 2'b11;
        end
      end
    end
  end
endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// tb/tb_ysyx_24100005_lsu.sv - directed bench with a behavioural LSU model over 32- and 64-bit instances
`timescale 1ns/1ps
module tb_ysyx_24100005_lsu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel;
  logic        req_valid, req_we, rsp_ready, mem_ready, mem_rvalid, mem_rerr;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, mem_rdata;

  logic        a_req_ready, a_rsp_valid, a_mem_valid, a_mem_we;
  logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
  logic [1:0]  a_rsp_err;
  logic [3:0]  a_mem_wmask;
  logic        b_req_ready, b_rsp_valid, b_mem_valid, b_mem_we;
  logic [63:0] b_rsp_rdata, b_mem_wdata;
  logic [31:0] b_mem_addr;
  logic [1:0]  b_rsp_err;
  logic [7:0]  b_mem_wmask;

  ysyx_24100005_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && !sel), .req_ready(a_req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .mem_valid(a_mem_valid), .mem_ready(mem_ready), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata[31:0]), .mem_rerr(mem_rerr)
  );

  ysyx_24100005_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(4)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && sel), .req_ready(b_req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .mem_valid(b_mem_valid), .mem_ready(mem_ready), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_rerr(mem_rerr)
  );

  logic        o_req_ready, o_rsp_valid, o_mem_valid, o_mem_we;
  logic [63:0] o_rsp_rdata, o_mem_wdata;
  logic [31:0] o_mem_addr;
  logic [1:0]  o_rsp_err;
  logic [7:0]  o_mem_wmask;

  always_comb begin
    if (sel) begin
      o_req_ready = b_req_ready; o_rsp_valid = b_rsp_valid; o_mem_valid = b_mem_valid;
      o_mem_we = b_mem_we; o_rsp_rdata = b_rsp_rdata; o_mem_wdata = b_mem_wdata;
      o_mem_addr = b_mem_addr; o_rsp_err = b_rsp_err; o_mem_wmask = b_mem_wmask;
    end else begin
      o_req_ready = a_req_ready; o_rsp_valid = a_rsp_valid; o_mem_valid = a_mem_valid;
      o_mem_we = a_mem_we; o_rsp_rdata = {32'h0, a_rsp_rdata}; o_mem_wdata = {32'h0, a_mem_wdata};
      o_mem_addr = a_mem_addr; o_rsp_err = a_rsp_err; o_mem_wmask = {4'h0, a_mem_wmask};
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // behavioural model: byte arithmetic on the access size and offset
  function automatic logic [1:0] m_err(input logic we, input logic [2:0] f3, input logic [31:0] addr, input int dw);
    int nb;
    nb = 1 << f3[1:0];
    if (f3 == 3'd7 || (f3 == 3'd3 && dw != 64) || (f3 == 3'd6 && (we || dw != 64)) || (f3[2] && we))
      return 2'd2;
    if ((addr % nb) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [63:0] word, input logic [31:0] addr, input int dw);
    int nb, off;
    logic [63:0] v, m;
    nb  = 1 << f3[1:0];
    off = addr % (dw / 8);
    v   = word >> (8 * off);
    m   = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v   = v & m;
    if (!f3[2] && v[8*nb-1]) v = v | ~m;
    if (dw == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  function automatic logic [7:0] m_wmask(input logic [2:0] f3, input logic [31:0] addr, input int dw);
    int nb, off;
    logic [15:0] m;
    nb  = 1 << f3[1:0];
    off = addr % (dw / 8);
    m   = ((16'd1 << nb) - 16'd1) << off;
    return m[7:0] & ((dw == 64) ? 8'hFF : 8'h0F);
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] wd, input logic [31:0] addr, input int dw);
    logic [63:0] v;
    v = wd << (8 * (addr % (dw / 8)));
    return (dw == 32) ? (v & 64'hFFFF_FFFF) : v;
  endfunction

  logic        chk_en = 1'b0;
  logic        e_we;
  logic [1:0]  e_err, e_rerr;
  logic [31:0] e_maddr;
  logic [7:0]  e_wmask;
  logic [63:0] e_wdata, e_rdata;
  logic [31:0] obs_maddr;
  logic [7:0]  obs_wmask;
  logic [63:0] obs_wdata;
  int          n_memv = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (o_mem_valid) begin
        n_memv++;
        obs_maddr = o_mem_addr; obs_wmask = o_mem_wmask; obs_wdata = o_mem_wdata;
        chk("mem_only_if_legal", {63'h0, (e_err == 2'd0)}, 64'd1);
        chk("mem_we", {63'h0, o_mem_we}, {63'h0, e_we});
        chk("mem_addr", {32'h0, o_mem_addr}, {32'h0, e_maddr});
        chk("mem_wmask", {56'h0, o_mem_wmask}, {56'h0, e_wmask});
        if (e_we) chk("mem_wdata", o_mem_wdata, e_wdata);
        chk("req_ready_in_issue", {63'h0, o_req_ready}, 64'd0);
      end
      if (o_rsp_valid) begin
        chk("rsp_rdata", o_rsp_rdata, e_rdata);
        chk("rsp_err", {62'h0, o_rsp_err}, {62'h0, e_rerr});
        chk("req_ready_in_resp", {63'h0, o_req_ready}, 64'd0);
      end
    end
  end

  // rv_dly < 0 means memory never answers
  task automatic txn(input logic s, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [63:0] wd, input logic [63:0] rd, input logic rerr,
                     input int rv_dly, input int mr_dly, input int hold,
                     output int lat, output logic [63:0] rdata_obs, output logic [1:0] err_obs);
    int dw, issue_n, wait_n, k;
    bit hs;
    dw = s ? 64 : 32;
    sel = s;
    mem_rdata = (dw == 32) ? (rd & 64'hFFFF_FFFF) : rd;
    mem_rerr  = rerr;
    e_we    = we;
    e_err   = m_err(we, f3, addr, dw);
    e_maddr = addr - (addr % (dw / 8));
    e_wmask = we ? m_wmask(f3, addr, dw) : 8'h00;
    e_wdata = m_wdata(wd, addr, dw);
    e_rerr  = (e_err != 2'd0) ? e_err : ((rv_dly < 0 || rerr) ? 2'd3 : 2'd0);
    e_rdata = (e_rerr != 2'd0 || we) ? 64'd0 : m_load(f3, mem_rdata, addr, dw);
    #1;
    chk("req_ready_before", {63'h0, o_req_ready}, 64'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    chk_en = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; issue_n = 0; wait_n = 0; hs = 1'b0; k = 0;
    while (!o_rsp_valid && k < 40) begin
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      if (!hs && o_mem_valid) begin
        mem_ready = (issue_n >= mr_dly);
        issue_n++;
      end else if (hs) begin
        mem_rvalid = (rv_dly >= 0 && wait_n == rv_dly);
        wait_n++;
      end
      @(posedge clk);
      if (mem_ready) hs = 1'b1;
      #1;
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      k++; lat++;
    end
    if (!o_rsp_valid) chk("rsp_within_bound", {63'h0, o_rsp_valid}, 64'd1);
    rdata_obs = o_rsp_rdata;
    err_obs   = o_rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("rsp_held", {63'h0, o_rsp_valid}, 64'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk_en = 1'b0;
    chk("idle_after_rsp", {62'h0, o_req_ready, o_rsp_valid}, 64'd2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, mv0;
    logic [63:0] rd;
    logic [1:0] er;
    rst = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 64'h0; rsp_ready = 1'b0; mem_ready = 1'b0;
    mem_rvalid = 1'b0; mem_rerr = 1'b0; mem_rdata = 64'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst32_ready", {63'h0, a_req_ready}, 64'd1);
    chk("rst32_outs", {a_rsp_valid, a_mem_valid, a_mem_we, a_rsp_err, a_mem_wmask, a_rsp_rdata, a_mem_addr}, 64'd0);
    chk("rst64_ready", {63'h0, b_req_ready}, 64'd1);
    chk("rst64_outs", {b_rsp_valid, b_mem_valid, b_mem_we, b_rsp_err, b_mem_wmask, b_mem_addr}, 64'd0);
    chk("rst64_data", b_rsp_rdata | b_mem_wdata, 64'd0);

    txn(0, 1, 3'b000, 32'h8000_0003, 64'hA5, 64'h0, 0, 0, 0, 0, lat, rd, er);
    chk("sb_addr", {32'h0, obs_maddr}, 64'h8000_0000);
    chk("sb_wmask", {56'h0, obs_wmask}, 64'h8);
    chk("sb_wdata", obs_wdata, 64'hA500_0000);
    chk("sb_rsp", {rd[61:0], er}, 64'd0);
    chk("min_latency", lat, 3);

    txn(0, 0, 3'b001, 32'h8000_0002, 64'h0, 64'h8123_4567, 0, 0, 0, 0, lat, rd, er);
    chk("lh", rd, 64'hFFFF_8123);
    txn(0, 0, 3'b101, 32'h8000_0002, 64'h0, 64'h8123_4567, 0, 1, 0, 0, lat, rd, er);
    chk("lhu", rd, 64'h0000_8123);
    txn(0, 0, 3'b000, 32'h8000_0001, 64'h0, 64'h8123_4567, 0, 2, 0, 0, lat, rd, er);
    chk("lb", rd, 64'h0000_0045);

    mv0 = n_memv;
    txn(0, 0, 3'b010, 32'h8000_0006, 64'h0, 64'h0, 0, 0, 0, 0, lat, rd, er);
    chk("lw_misaligned", er, 2'b01);
    chk("misaligned_no_mem", n_memv, mv0);
    chk("err_latency", lat, 1);
    txn(0, 0, 3'b111, 32'h8000_0001, 64'h0, 64'h0, 0, 0, 0, 0, lat, rd, er);
    chk("f3_111", er, 2'b10);
    txn(0, 0, 3'b011, 32'h8000_0000, 64'h0, 64'h0, 0, 0, 0, 0, lat, rd, er);
    chk("ld_on_32", er, 2'b10);
    txn(0, 1, 3'b100, 32'h8000_0000, 64'h0, 64'h0, 0, 0, 0, 0, lat, rd, er);
    chk("sbu_illegal", er, 2'b10);

    txn(0, 0, 3'b010, 32'h8000_0000, 64'h0, 64'h0, 0, -1, 0, 0, lat, rd, er);
    chk("timeout_err", er, 2'b11);
    chk("timeout_latency", lat, 6);
    mem_rvalid = 1'b1; mem_rdata = 64'h1234_5678;
    @(posedge clk); #1 mem_rvalid = 1'b0;
    @(posedge clk); #1;
    chk("late_rvalid_ignored", {o_req_ready, o_rsp_valid, o_mem_valid}, 64'd4);

    txn(0, 0, 3'b010, 32'h8000_0010, 64'h0, 64'h0BAD_F00D, 0, 1, 3, 5, lat, rd, er);
    chk("held_lw", rd, 64'h0BAD_F00D);
    txn(0, 1, 3'b001, 32'h8000_0012, 64'hBEEF, 64'h0, 0, 0, 3, 0, lat, rd, er);
    chk("sh_wmask", {56'h0, obs_wmask}, 64'hC);
    chk("sh_wdata", obs_wdata, 64'hBEEF_0000);
    txn(0, 0, 3'b010, 32'h8000_0000, 64'h0, 64'h1111_2222, 1, 0, 0, 0, lat, rd, er);
    chk("bus_err", {rd[61:0], er}, 64'd3);

    sel = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0000;
    @(posedge clk); #1 req_valid = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1 mem_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    #2;
    chk("rst_wait_ready", {63'h0, o_req_ready}, 64'd1);
    chk("rst_wait_outs", {o_rsp_valid, o_mem_valid, o_mem_we, o_rsp_err, o_mem_wmask, o_mem_addr}, 64'd0);
    chk("rst_wait_data", o_rsp_rdata | o_mem_wdata, 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'h5555_5555;
    @(posedge clk); #1 mem_rvalid = 1'b0;
    chk("inflight_ignored", {o_req_ready, o_rsp_valid, o_mem_valid}, 64'd4);
    txn(0, 0, 3'b010, 32'h8000_0000, 64'h0, 64'hDEAD_BEEF, 0, 0, 0, 0, lat, rd, er);
    chk("lw_after_rst", rd, 64'hDEAD_BEEF);

    txn(1, 0, 3'b110, 32'h8000_0004, 64'h0, 64'h8000_0001_0000_0000, 0, 0, 0, 0, lat, rd, er);
    chk("lwu64", rd, 64'h0000_0000_8000_0001);
    txn(1, 0, 3'b010, 32'h8000_0004, 64'h0, 64'h8000_0001_0000_0000, 0, 0, 0, 0, lat, rd, er);
    chk("lw64", rd, 64'hFFFF_FFFF_8000_0001);
    txn(1, 1, 3'b011, 32'h8000_0008, 64'h1122_3344_5566_7788, 64'h0, 0, 0, 0, 0, lat, rd, er);
    chk("sd_wmask", {56'h0, obs_wmask}, 64'hFF);
    chk("sd_addr", {32'h0, obs_maddr}, 64'h8000_0008);
    txn(1, 1, 3'b010, 32'h8000_0004, 64'hCAFE_BABE, 64'h0, 0, 0, 0, 0, lat, rd, er);
    chk("sw64_wdata", obs_wdata, 64'hCAFE_BABE_0000_0000);
    txn(1, 0, 3'b011, 32'h8000_0004, 64'h0, 64'h0, 0, 0, 0, 0, lat, rd, er);
    chk("ld_misaligned", er, 2'b01);
    txn(1, 1, 3'b110, 32'h8000_0003, 64'h0, 64'h0, 0, 0, 0, 0, lat, rd, er);
    chk("swu_illegal_first", er, 2'b10);
    txn(1, 0, 3'b011, 32'h8000_0000, 64'h0, 64'hF0E1_D2C3_B4A5_9687, 0, 0, 0, 0, lat, rd, er);
    chk("ld64", rd, 64'hF0E1_D2C3_B4A5_9687);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
